// File: rtl/conv_tile_sched.sv
// Raster scheduler for the conv -> quant datapath: issues one window per output
// pixel under credit flow control and streams results out of an in-order FIFO.
module conv_tile_sched #(
  parameter int DIM_W      = 6,
  parameter int FIFO_DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic [DIM_W-1:0] cfg_rows,
  input  logic [DIM_W-1:0] cfg_cols,
  output logic             busy,
  output logic             done,
  output logic             win_valid,
  output logic [DIM_W-1:0] win_row,
  output logic [DIM_W-1:0] win_col,
  input  logic             q_finish,
  input  logic [7:0]       q_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic [DIM_W-1:0] out_row,
  output logic [DIM_W-1:0] out_col,
  output logic             out_last,
  output logic             err,
  output logic [1:0]       state_dbg
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2} state_t;

  // Handshake: a result leaves the FIFO on any cycle where out_valid && out_ready
  // are both high; out_valid never depends on out_ready.
  state_t           state, state_nx;
  logic [DIM_W-1:0] rows_q, cols_q;
  logic [CW-1:0]    credits, count;
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [7:0]       mem [FIFO_DEPTH];
  logic             start, issue, issue_last, pop, push, full, err_set;

  assign issue_last = (win_row == rows_q) && (win_col == cols_q);
  assign out_valid  = (count != '0);
  assign pop        = out_valid && out_ready;
  assign full       = (count == CW'(FIFO_DEPTH));
  assign push       = q_finish && (state != IDLE) && (!full || pop);
  assign err_set    = q_finish && ((state == IDLE) || (full && !pop));
  assign out_last   = out_valid && (out_row == rows_q) && (out_col == cols_q);
  assign out_data   = out_valid ? mem[rd_ptr] : 8'd0;
  assign busy       = (state != IDLE);
  assign win_valid  = issue;
  assign state_dbg  = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    issue    = 1'b0;
    case (state)
      IDLE: if (go) begin
        start    = 1'b1;
        state_nx = ISSUE;
      end
      ISSUE: begin
        // Registered credits only: a pop this cycle frees a slot next cycle.
        issue = (credits < CW'(FIFO_DEPTH));
        if (issue && issue_last) state_nx = DRAIN;
      end
      DRAIN: if (pop && out_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rows_q  <= '0;
      cols_q  <= '0;
      win_row <= '0;
      win_col <= '0;
      out_row <= '0;
      out_col <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= (state == DRAIN) && pop && out_last;
      if (err_set) err <= 1'b1;
      if (start) begin
        rows_q  <= cfg_rows;
        cols_q  <= cfg_cols;
        win_row <= '0;
        win_col <= '0;
        out_row <= '0;
        out_col <= '0;
      end else begin
        if (issue) begin
          if (win_col == cols_q) begin
            win_col <= '0;
            win_row <= win_row + DIM_W'(1);
          end else begin
            win_col <= win_col + DIM_W'(1);
          end
        end
        if (pop) begin
          if (out_col == cols_q) begin
            out_col <= '0;
            out_row <= out_row + DIM_W'(1);
          end else begin
            out_col <= out_col + DIM_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits <= '0;
      count   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
    end else begin
      case ({issue, pop})
        2'b10:   credits <= credits + CW'(1);
        2'b01:   credits <= credits - CW'(1);
        default: credits <= credits;
      endcase
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= q_result;
  end

endmodule

// File: tb/tb_conv_tile_sched.sv
// Directed bench for conv_tile_sched with a 7-cycle echo datapath and a raster
// reference model feeding an expected-data queue.
module tb_conv_tile_sched;
  localparam int DIM_W = 6;
  localparam int DEPTH = 16;
  localparam int LAT   = 7;

  logic             clk = 1'b0;
  logic             rst_n, go, out_ready;
  logic [DIM_W-1:0] cfg_rows, cfg_cols;
  logic             busy, done, win_valid, out_valid, out_last, err;
  logic [DIM_W-1:0] win_row, win_col, out_row, out_col;
  logic [7:0]       out_data;
  logic [1:0]       state_dbg;
  logic             q_finish;
  logic [7:0]       q_result;
  logic             e_fin = 1'b0, inj_fin = 1'b0;
  logic [7:0]       e_res = 8'd0, inj_res = 8'd0;

  assign q_finish = e_fin | inj_fin;
  assign q_result = inj_fin ? inj_res : e_res;

  conv_tile_sched #(.DIM_W(DIM_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .cfg_rows(cfg_rows), .cfg_cols(cfg_cols),
    .busy(busy), .done(done), .win_valid(win_valid), .win_row(win_row),
    .win_col(win_col), .q_finish(q_finish), .q_result(q_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_col(out_col), .out_last(out_last), .err(err),
    .state_dbg(state_dbg)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0, bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pix(input logic [DIM_W-1:0] r, input logic [DIM_W-1:0] c);
    return {r[3:0], c[3:0]} ^ 8'hA5;
  endfunction

  // echo datapath: window issued in cycle t returns as q_finish in cycle t+7
  logic       vq [LAT];
  logic [7:0] dq [LAT];
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) vq[i] = 1'b0;
      e_fin = 1'b0;
    end else begin
      e_fin = vq[LAT-1];
      e_res = dq[LAT-1];
      for (int i = LAT - 1; i > 0; i--) begin
        vq[i] = vq[i-1];
        dq[i] = dq[i-1];
      end
      vq[0] = win_valid;
      dq[0] = pix(win_row, win_col);
    end
  end

  // scoreboard: raster reference for issues and pops
  logic [7:0] exp_q[$];
  int  cfg_r, cfg_c, iss_r, iss_c, pop_r, pop_c;
  int  n_iss, n_pop, n_last, first_iss, last_iss, first_pop, last_pop, iss17, go_cyc;
  bit  mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (win_valid) begin
        check("win_row", win_row, iss_r);
        check("win_col", win_col, iss_c);
        exp_q.push_back(pix(DIM_W'(iss_r), DIM_W'(iss_c)));
        if (n_iss == 0) first_iss = cyc;
        last_iss = cyc;
        n_iss++;
        if (n_iss == 17) iss17 = cyc;
        if (iss_c == cfg_c) begin iss_c = 0; iss_r++; end
        else iss_c++;
      end
      if (out_valid && out_ready) begin
        check("out_row", out_row, pop_r);
        check("out_col", out_col, pop_c);
        check("out_last", out_last, (pop_r == cfg_r) && (pop_c == cfg_c));
        if (exp_q.size() == 0) check("spurious_pop", n_pop + 1, n_iss);
        else check("out_data", out_data, exp_q.pop_front());
        if (n_pop == 0) first_pop = cyc;
        last_pop = cyc;
        n_pop++;
        if (out_last) n_last++;
        if (pop_c == cfg_c) begin pop_c = 0; pop_r++; end
        else pop_c++;
      end
    end
  end

  // driver tasks
  task automatic model_reset();
    exp_q.delete();
    iss_r = 0; iss_c = 0; pop_r = 0; pop_c = 0;
    n_iss = 0; n_pop = 0; n_last = 0;
    first_iss = -1; last_iss = -1; first_pop = -1; last_pop = -1; iss17 = -1;
  endtask

  task automatic start_map(input int r, input int c);
    model_reset();
    cfg_r = r;
    cfg_c = c;
    @(posedge clk); #1;
    cfg_rows = DIM_W'(r);
    cfg_cols = DIM_W'(c);
    go = 1'b1;
    go_cyc = cyc;
    @(posedge clk); #1;
    go = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (done) break;
    end
    check("done_seen", done, 1);
    check("done_after_last_pop", cyc, last_pop + 1);
    check("busy_at_done", busy, 0);
    @(negedge clk);
    check("done_pulse_width", done, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_win_valid"}, win_valid, 0);
    check({tag, "_win_row"}, win_row, 0);
    check({tag, "_win_col"}, win_col, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_out_row"}, out_row, 0);
    check({tag, "_out_col"}, out_col, 0);
    check({tag, "_out_last"}, out_last, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_state"}, state_dbg, 0);
  endtask

  initial begin
    rst_n = 1'b0; go = 1'b0; out_ready = 1'b1;
    cfg_rows = '0; cfg_cols = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    mon_en = 1'b1;

    // 3x4 map, full throughput
    start_map(2, 3);
    wait_done(200);
    check("m34_issues", n_iss, 12);
    check("m34_pops", n_pop, 12);
    check("m34_lasts", n_last, 1);
    check("m34_first_issue_cyc", first_iss, go_cyc + 1);
    check("m34_issue_span", last_iss - first_iss, 11);
    check("m34_pop_span", last_pop - first_pop, 11);
    check("m34_sb_left", exp_q.size(), 0);
    check("m34_err", err, 0);

    // backpressure: 5x5 map, out_ready low for 40 cycles
    @(posedge clk); #1;
    out_ready = 1'b0;
    start_map(4, 4);
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("bp_issues_capped", n_iss, DEPTH);
    check("bp_win_valid_low", win_valid, 0);
    check("bp_err", err, 0);
    check("bp_out_valid", out_valid, 1);
    check("bp_busy", busy, 1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_done(300);
    check("bp_credit_return_cyc", iss17, first_pop + 1);
    check("bp_issues", n_iss, 25);
    check("bp_pops", n_pop, 25);
    check("bp_lasts", n_last, 1);
    check("bp_err_end", err, 0);

    // 1x1 map
    start_map(0, 0);
    wait_done(100);
    check("m11_issues", n_iss, 1);
    check("m11_pops", n_pop, 1);
    check("m11_lasts", n_last, 1);
    check("m11_first_issue_cyc", first_iss, go_cyc + 1);

    // go pulses during ISSUE and DRAIN are ignored
    start_map(1, 2);
    check("ign_in_issue", state_dbg, 1);
    cfg_rows = 6'd5; cfg_cols = 6'd5; go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (state_dbg == 2'd2) break;
    end
    check("ign_in_drain", state_dbg, 2);
    @(posedge clk); #1;
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    wait_done(100);
    check("ign_issues", n_iss, 6);
    check("ign_pops", n_pop, 6);
    check("ign_lasts", n_last, 1);
    repeat (5) @(negedge clk);
    check("ign_idle_busy", busy, 0);
    check("ign_no_extra_issue", n_iss, 6);

    // unsolicited q_finish in IDLE
    check("pre_inj_err", err, 0);
    @(posedge clk); #1;
    inj_fin = 1'b1; inj_res = 8'h3C;
    @(posedge clk); #1;
    inj_fin = 1'b0;
    @(negedge clk);
    check("inj_err", err, 1);
    check("inj_out_valid", out_valid, 0);
    check("inj_busy", busy, 0);
    repeat (3) @(negedge clk);
    check("inj_out_valid_later", out_valid, 0);
    check("inj_err_sticky", err, 1);

    // reset mid-map after 5 pops, then a clean 2x2 map
    start_map(3, 3);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk); #1;
      if (n_pop >= 5) break;
    end
    check("mid_pops", n_pop, 5);
    rst_n = 1'b0;
    mon_en = 1'b0;
    #1;
    check_reset_vals("async_rst");
    @(negedge clk);
    check_reset_vals("held_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    mon_en = 1'b1;
    start_map(1, 1);
    wait_done(100);
    check("m22_issues", n_iss, 4);
    check("m22_pops", n_pop, 4);
    check("m22_lasts", n_last, 1);
    check("m22_err", err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
